icache_boot_ctrl: RTL

- Sequences power-up loading of the instruction SRAM from a 32-bit valid/ready word stream.
- Drives the icache boot write port (boot_up/boot_web/boot_addr/boot_datai) and holds the pipeline in reset until the image is loaded.
- Then releases the CPU so the icache address mux switches to the PC.
- Replaces hand-sequenced boot stimulus with a synthesizable controller sitting between the external loader and top_pipe/icache.

---
 rtl/icache_boot_ctrl_pkg.sv | 17 +
 rtl/icache_boot_ctrl_word_counter.sv | 39 +++
 rtl/icache_boot_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/icache_boot_ctrl_pkg.sv
// Shared definitions for the icache boot controller: default icache geometry and
// the boot sequencer state encoding.
package icache_boot_ctrl_pkg;

  localparam int unsigned ICACHE_ADDR_W = 8;
  localparam int unsigned INSN_W        = 32;

  typedef enum logic [2:0] {
    BOOT_IDLE    = 3'd0,
    BOOT_LOAD    = 3'd1,
    BOOT_FLUSH   = 3'd2,
    BOOT_RELEASE = 3'd3,
    BOOT_DONE    = 3'd4,
    BOOT_FAIL    = 3'd5
  } boot_state_e;

endpackage

// File: rtl/icache_boot_ctrl_word_counter.sv
// Boot word counter: loadable up-counter holding the image length, with a
// terminal-count compare. With TcOnFull=0 tc flags that the next increment reaches
// len; with TcOnFull=1 tc flags that cnt already equals len (trailing word pending).
module icache_boot_ctrl_word_counter #(
  parameter int unsigned ADDR_W   = 8,
  parameter bit          TcOnFull = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W:0]   len,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] cnt_plus;

  assign cnt_plus = cnt_q + (ADDR_W + 1)'(1);

  // Counter and latched length; load clears the count for a new image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      len_q <= len;
    end else if (inc) begin
      cnt_q <= cnt_plus;
    end
  end

  assign addr = cnt_q[ADDR_W-1:0];
  assign tc   = TcOnFull ? (cnt_q == len_q) : (cnt_plus == len_q);

endmodule

// File: rtl/icache_boot_ctrl.sv
// icache boot controller: streams a code image from a valid/ready word source into
// the icache boot write port, holding the CPU pipeline in reset until loaded.
// Optional feature macro BOOT_CHECKSUM_EN: a trailing word carrying the 32-bit
// wrap-around sum of the image is accepted and checked before releasing the CPU.
module icache_boot_ctrl
  import icache_boot_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = ICACHE_ADDR_W,
  parameter int unsigned DATA_W  = INSN_W,
  parameter int unsigned MAX_LEN = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   code_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              boot_up,
  output logic              boot_web,
  output logic [ADDR_W-1:0] boot_addr,
  output logic [DATA_W-1:0] boot_datai,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

`ifdef BOOT_CHECKSUM_EN
  localparam bit TcOnFull = 1'b1;
`else
  localparam bit TcOnFull = 1'b0;
`endif

  boot_state_e state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              boot_up_q, boot_up_d;
  logic              boot_web_q, boot_web_d;
  logic [ADDR_W-1:0] boot_addr_q, boot_addr_d;
  logic [DATA_W-1:0] boot_datai_q, boot_datai_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  // Extra RELEASE cycle so the icache address mux settles on the PC before reset lifts.
  logic              settle_q, settle_d;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  logic              cnt_load;
  logic              cnt_inc;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_tc;
  logic              hs;
  logic              len_ok;

  assign hs     = in_valid & in_ready_q;
  assign len_ok = (code_len != '0) && (32'(code_len) <= MAX_LEN);

  icache_boot_ctrl_word_counter #(
    .ADDR_W   (ADDR_W),
    .TcOnFull (TcOnFull)
  ) u_word_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_load),
    .len  (code_len),
    .inc  (cnt_inc),
    .addr (cnt_addr),
    .tc   (cnt_tc)
  );

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    boot_up_d    = boot_up_q;
    boot_web_d   = 1'b1;
    boot_addr_d  = boot_addr_q;
    boot_datai_d = boot_datai_q;
    cpu_rst_n_d  = cpu_rst_n_q;
    done_d       = done_q;
    err_d        = err_q;
    settle_d     = settle_q;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    unique case (state_q)
      BOOT_IDLE, BOOT_DONE, BOOT_FAIL: begin
        if (start) begin
          done_d      = 1'b0;
          cpu_rst_n_d = 1'b0;
          if (len_ok) begin
            state_d    = BOOT_LOAD;
            cnt_load   = 1'b1;
            in_ready_d = 1'b1;
            boot_up_d  = 1'b1;
            err_d      = 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_d      = '0;
`endif
          end else begin
            state_d    = BOOT_FAIL;
            in_ready_d = 1'b0;
            boot_up_d  = 1'b0;
            err_d      = 1'b1;
          end
        end
      end
      BOOT_LOAD: begin
        if (hs) begin
`ifdef BOOT_CHECKSUM_EN
          if (!cnt_tc) begin
            boot_web_d   = 1'b0;
            boot_addr_d  = cnt_addr;
            boot_datai_d = in_data;
            cnt_inc      = 1'b1;
            sum_d        = sum_q + in_data;
          end else begin
            // Checksum word: compared, never written to the icache.
            in_ready_d   = 1'b0;
            boot_addr_d  = '0;
            boot_datai_d = '0;
            if (in_data == sum_q) begin
              state_d = BOOT_FLUSH;
            end else begin
              state_d   = BOOT_FAIL;
              boot_up_d = 1'b0;
              err_d     = 1'b1;
            end
          end
`else
          boot_web_d   = 1'b0;
          boot_addr_d  = cnt_addr;
          boot_datai_d = in_data;
          cnt_inc      = 1'b1;
          if (cnt_tc) begin
            state_d    = BOOT_FLUSH;
            in_ready_d = 1'b0;
          end
`endif
        end
      end
      BOOT_FLUSH: begin
        state_d      = BOOT_RELEASE;
        boot_addr_d  = '0;
        boot_datai_d = '0;
        boot_up_d    = 1'b0;
        settle_d     = 1'b0;
      end
      BOOT_RELEASE: begin
        if (!settle_q) begin
          settle_d = 1'b1;
        end else begin
          state_d     = BOOT_DONE;
          cpu_rst_n_d = 1'b1;
          done_d      = 1'b1;
        end
      end
      default: state_d = BOOT_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT_IDLE;
      in_ready_q   <= 1'b0;
      boot_up_q    <= 1'b0;
      boot_web_q   <= 1'b1;
      boot_addr_q  <= '0;
      boot_datai_q <= '0;
      cpu_rst_n_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      settle_q     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      boot_up_q    <= boot_up_d;
      boot_web_q   <= boot_web_d;
      boot_addr_q  <= boot_addr_d;
      boot_datai_q <= boot_datai_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
      settle_q     <= settle_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign boot_up    = boot_up_q;
  assign boot_web   = boot_web_q;
  assign boot_addr  = boot_addr_q;
  assign boot_datai = boot_datai_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
